// File: rtl/dmem_pkg.sv
// Shared types and default parameters for the wait-state data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_DEPTH   = 64;
  localparam int DEF_LATENCY = 2;

  // Number of byte-offset address bits below the word index.
  function automatic int offset_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/lat_counter.sv
// Loadable down-counter; zero asserts when the counter reaches zero this cycle.
// Combinational flag, one register stage; load takes priority over dec.
module lat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  // While decrementing, the flag looks at the value the counter lands on so
  // the owner can leave its wait state on the same edge the count expires.
  assign zero = dec ? (count <= W'(1)) : (count == '0);

endmodule

// File: rtl/dmem_wait.sv
// Single-port byte-lane data memory answering each request after a fixed latency.
// ready is high only when idle; requests seen while busy are dropped, not queued.
module dmem_wait
  import dmem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                we,
  input  logic [31:0]         addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic                ready,
  output logic                ack,
  output logic [DATA_W-1:0]   rdata,
  output logic                err
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = offset_bits(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(LATENCY) + 1;
  localparam logic [31:0] OFF_MASK = (32'd1 << OFF_W) - 32'd1;

  state_t            state;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NB-1:0]     be_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              to_resp;
  logic              cnt_zero;
  logic              cur_we;
  logic [31:0]       cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [NB-1:0]     cur_be;
  logic [31:0]       word_idx;
  logic [IDX_W-1:0]  idx;
  logic              misaligned;
  logic              out_of_range;
  logic              bad;

  assign ready  = (state == IDLE);
  assign accept = req && ready;

  // With LATENCY=1 the response edge is the accepting edge, so the request
  // fields come straight from the ports rather than the capture registers.
  assign cur_we    = (state == IDLE) ? we    : we_q;
  assign cur_addr  = (state == IDLE) ? addr  : addr_q;
  assign cur_wdata = (state == IDLE) ? wdata : wdata_q;
  assign cur_be    = (state == IDLE) ? be    : be_q;

  assign word_idx     = cur_addr >> OFF_W;
  assign idx          = word_idx[IDX_W-1:0];
  assign misaligned   = |(cur_addr & OFF_MASK);
  assign out_of_range = (word_idx >= 32'(DEPTH));
  assign bad          = misaligned || out_of_range;

  assign to_resp = (accept && (LATENCY == 1)) || ((state == WAIT) && cnt_zero);

  lat_counter #(
    .W (CW)
  ) u_lat (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (CW'(LATENCY - 1)),
    .dec      (state == WAIT),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
      unique case (state)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            be_q    <= be;
            state   <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt_zero) begin
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
      if (to_resp) begin
        ack <= 1'b1;
        err <= bad;
        if (!cur_we && !bad) begin
          rdata <= mem[idx];
        end
      end
    end
  end

  // Storage has no reset; an aborted transaction never reaches this write.
  always_ff @(posedge clk) begin
    if (!reset && to_resp && cur_we && !bad) begin
      for (int i = 0; i < NB; i++) begin
        if (cur_be[i]) begin
          mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_wait.sv
// Directed bench for dmem_wait at DATA_W=32, DEPTH=64, LATENCY=2.
module tb_dmem_wait;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ready;
  logic        ack;
  logic [31:0] rdata;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_wait #(
    .DATA_W  (32),
    .DEPTH   (64),
    .LATENCY (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .be    (be),
    .ready (ready),
    .ack   (ack),
    .rdata (rdata),
    .err   (err)
  );

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, want finish before 200000");
    $fatal(1, "watchdog");
  end

  // One request; reports the cycle after acceptance where ack first appears.
  task automatic txn(input logic t_we, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                     input logic [3:0] t_be, output int ack_at, output int ack_cnt,
                     output logic [31:0] r_dat, output logic r_err);
    int waited;
    waited  = 0;
    ack_at  = 0;
    ack_cnt = 0;
    r_dat   = '0;
    r_err   = 1'b0;
    @(negedge clk);
    while (ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got %b want 1", ready);
    end
    req   = 1'b1;
    we    = t_we;
    addr  = t_addr;
    wdata = t_wdata;
    be    = t_be;
    @(posedge clk);
    #1 req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        ack_cnt++;
        if (ack_at == 0) begin
          ack_at = k;
          r_dat  = rdata;
          r_err  = err;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 1'b1;
    we    = 1'b1;
    addr  = 32'h0;
    wdata = 32'hFFFF_FFFF;
    be    = 4'hF;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_held ready=%b ack=%b want ready=1 ack=0", ready, ack);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    req   = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", ack); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 00000000", rdata); end
  endtask

  task automatic test_write_read();
    int at, cnt;
    logic [31:0] d;
    logic e;
    txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, at, cnt, d, e);
    checks++;
    if (at != 2 || cnt != 1) begin
      errors++;
      $display("FAIL wr_ack_timing at=%0d cnt=%0d want at=2 cnt=1", at, cnt);
    end
    checks++;
    if (e !== 1'b0 || d !== 32'h0) begin
      errors++;
      $display("FAIL wr_resp err=%b rdata=%h want err=0 rdata=00000000", e, d);
    end
    txn(1'b0, 32'h10, 32'h0, 4'h0, at, cnt, d, e);
    checks++;
    if (at != 2 || cnt != 1) begin
      errors++;
      $display("FAIL rd_ack_timing at=%0d cnt=%0d want at=2 cnt=1", at, cnt);
    end
    checks++;
    if (d !== 32'hDEAD_BEEF || e !== 1'b0) begin
      errors++;
      $display("FAIL rd_data got %h err=%b want deadbeef err=0", d, e);
    end
  endtask

  task automatic test_byte_lanes();
    int at, cnt;
    logic [31:0] d;
    logic e;
    txn(1'b1, 32'h10, 32'h1122_3344, 4'h5, at, cnt, d, e);
    txn(1'b0, 32'h10, 32'h0, 4'h0, at, cnt, d, e);
    checks++;
    if (d !== 32'hDE22_BE44) begin errors++; $display("FAIL be_partial got %h want de22be44", d); end
    txn(1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, at, cnt, d, e);
    checks++;
    if (at != 2 || e !== 1'b0) begin
      errors++;
      $display("FAIL be_zero_ack at=%0d err=%b want at=2 err=0", at, e);
    end
    txn(1'b0, 32'h10, 32'h0, 4'h0, at, cnt, d, e);
    checks++;
    if (d !== 32'hDE22_BE44) begin errors++; $display("FAIL be_zero_keep got %h want de22be44", d); end
    txn(1'b1, 32'hFC, 32'hA5A5_0FF0, 4'hF, at, cnt, d, e);
    txn(1'b0, 32'hFC, 32'h0, 4'h0, at, cnt, d, e);
    checks++;
    if (d !== 32'hA5A5_0FF0 || e !== 1'b0) begin
      errors++;
      $display("FAIL last_word got %h err=%b want a5a50ff0 err=0", d, e);
    end
  endtask

  task automatic test_errors();
    int at, cnt;
    logic [31:0] d;
    logic e;
    txn(1'b1, 32'h12, 32'h1234_5678, 4'hF, at, cnt, d, e);
    checks++;
    if (at != 2 || e !== 1'b1 || d !== 32'h0) begin
      errors++;
      $display("FAIL misaligned at=%0d err=%b rdata=%h want at=2 err=1 rdata=00000000", at, e, d);
    end
    txn(1'b0, 32'h100, 32'h0, 4'h0, at, cnt, d, e);
    checks++;
    if (at != 2 || e !== 1'b1 || d !== 32'h0) begin
      errors++;
      $display("FAIL out_of_range at=%0d err=%b rdata=%h want at=2 err=1 rdata=00000000", at, e, d);
    end
    txn(1'b0, 32'h10, 32'h0, 4'h0, at, cnt, d, e);
    checks++;
    if (d !== 32'hDE22_BE44 || e !== 1'b0) begin
      errors++;
      $display("FAIL err_no_write got %h err=%b want de22be44 err=0", d, e);
    end
  endtask

  task automatic test_reset_abort();
    int at, cnt, seen;
    logic [31:0] d;
    logic e;
    txn(1'b1, 32'h20, 32'h0, 4'hF, at, cnt, d, e);
    @(negedge clk);
    req   = 1'b1;
    we    = 1'b1;
    addr  = 32'h20;
    wdata = 32'hCAFE_F00D;
    be    = 4'hF;
    @(posedge clk);
    #1;
    req   = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    seen = 0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", ready); end
    for (int k = 0; k < 4; k++) begin
      if (ack === 1'b1) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL abort_ack got %0d acks want 0", seen); end
    txn(1'b0, 32'h20, 32'h0, 4'h0, at, cnt, d, e);
    checks++;
    if (d !== 32'h0 || e !== 1'b0) begin
      errors++;
      $display("FAIL abort_mem got %h err=%b want 00000000 err=0", d, e);
    end
    txn(1'b0, 32'h10, 32'h0, 4'h0, at, cnt, d, e);
    checks++;
    if (d !== 32'hDE22_BE44) begin errors++; $display("FAIL mem_kept got %h want de22be44", d); end
  endtask

  // req held high: pattern per cycle after each acceptance is WAIT, RESP, IDLE.
  task automatic test_back_to_back();
    logic exp_ready, exp_ack;
    @(negedge clk);
    req   = 1'b1;
    we    = 1'b0;
    addr  = 32'h10;
    wdata = 32'h0;
    be    = 4'h0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      exp_ready = (c % 3 == 2);
      exp_ack   = (c % 3 == 1);
      checks++;
      if (ready !== exp_ready || ack !== exp_ack) begin
        errors++;
        $display("FAIL b2b_cycle%0d ready=%b ack=%b want ready=%b ack=%b",
                 c, ready, ack, exp_ready, exp_ack);
      end
      if (exp_ack) begin
        checks++;
        if (rdata !== 32'hDE22_BE44) begin
          errors++;
          $display("FAIL b2b_data%0d got %h want de22be44", c, rdata);
        end
      end
    end
    req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    req   = 1'b0;
    we    = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
    be    = 4'h0;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
